// File: rtl/rv32im_pkg.sv
// Shared RV32M encodings: funct3 opcodes and the mul/div FSM state encoding,
// also used by decode so both sides agree on the numbering.
package rv32im_pkg;

  typedef logic [2:0] funct3_t;

  localparam funct3_t F3_MUL    = 3'b000;
  localparam funct3_t F3_MULH   = 3'b001;
  localparam funct3_t F3_MULHSU = 3'b010;
  localparam funct3_t F3_MULHU  = 3'b011;
  localparam funct3_t F3_DIV    = 3'b100;
  localparam funct3_t F3_DIVU   = 3'b101;
  localparam funct3_t F3_REM    = 3'b110;
  localparam funct3_t F3_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_FIX  = ST_FIX,
    S_DONE = ST_DONE
  } state_e;

  function automatic logic is_div_op(funct3_t f);
    return f[2];
  endfunction

endpackage

// File: rtl/rv32im_muldiv_if.sv
// Request/response bundle between execute/writeback and the mul/div unit.
interface rv32im_muldiv_if
  import rv32im_pkg::*;
#(
  parameter int unsigned XLEN = 32
);
  logic            start;
  funct3_t         funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/rv32im_muldiv.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps on
// operand magnitudes in one shared 64-bit accumulator, then a sign-fix cycle.
module rv32im_muldiv
  import rv32im_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            RESET,
  input  logic            start,
  input  funct3_t         funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int unsigned     W2     = 2 * XLEN;
  localparam logic [5:0]      LAST   = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN   = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] opb_q, opb_d;
  funct3_t         f3_q, f3_d;
  logic [4:0]      rd_q, rd_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;

  logic            a_signed, b_signed, a_neg, b_neg, neg_req;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN:0]   mul_sum, div_rem, div_diff;
  logic [W2-1:0]   prod;
  logic [XLEN-1:0] div_raw, div_res;

  assign a_signed = !(funct3 == F3_MULHU || funct3 == F3_DIVU || funct3 == F3_REMU);
  assign b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                    (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign a_neg    = a_signed && rs1_val[XLEN-1];
  assign b_neg    = b_signed && rs2_val[XLEN-1];
  assign a_mag    = a_neg ? -rs1_val : rs1_val;
  assign b_mag    = b_neg ? -rs2_val : rs2_val;
  // Remainder follows the dividend's sign; every other result uses sign(a)^sign(b).
  assign neg_req  = (funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
  assign div_zero = is_div_op(funct3) && (rs2_val == '0);
  assign div_ovf  = (funct3 == F3_DIV || funct3 == F3_REM) &&
                    (rs1_val == SMIN) && (rs2_val == '1);

  assign mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign div_rem  = acc_q[W2-1:XLEN-1];
  assign div_diff = div_rem - {1'b0, opb_q};

  assign prod     = neg_q ? -acc_q : acc_q;
  assign div_raw  = f3_q[1] ? acc_q[W2-1:XLEN] : acc_q[XLEN-1:0];
  assign div_res  = neg_q ? -div_raw : div_raw;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d  = funct3;
          rd_d  = rd_in;
          neg_d = neg_req;
          opb_d = b_mag;
          acc_d = {{XLEN{1'b0}}, a_mag};
          cnt_d = '0;
          if (div_zero) begin
            state_d  = S_DONE;
            result_d = funct3[1] ? rs1_val : '1;
            rd_out_d = rd_in;
          end else if (div_ovf) begin
            state_d  = S_DONE;
            result_d = funct3[1] ? '0 : SMIN;
            rd_out_d = rd_in;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (is_div_op(f3_q)) begin
          // Hi half holds the partial remainder; trial subtract includes the bit shifted out.
          if (!div_diff[XLEN])
            acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else
            acc_d = {acc_q[W2-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_op(f3_q))
          result_d = div_res;
        else
          result_d = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[W2-1:XLEN];
        rd_out_d = rd_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        result_d = '0;
        rd_out_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_rv32im_muldiv.sv
// Scoreboard bench for rv32im_muldiv: expected result, rd and completion cycle are
// queued at issue and compared on every done strobe.
module tb_rv32im_muldiv;
  import rv32im_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned accepted = 0;
  int unsigned dones = 0;
  logic        prev_done = 1'b0;
  exp_t        sb[$];

  rv32im_muldiv_if #(.XLEN(32)) bus ();

  rv32im_muldiv #(.XLEN(32)) dut (
    .clk     (clk),
    .RESET   (RESET),
    .start   (bus.start),
    .funct3  (bus.funct3),
    .rs1_val (bus.rs1_val),
    .rs2_val (bus.rs2_val),
    .rd_in   (bus.rd_in),
    .busy    (bus.busy),
    .done    (bus.done),
    .result  (bus.result),
    .rd_out  (bus.rd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ax, bx, p;
    int sa, sb_;
    sa  = a;
    sb_ = b;
    ax  = (f3 == F3_MULHU) ? {32'h0, a} : {{32{a[31]}}, a};
    bx  = (f3 == F3_MULHU || f3 == F3_MULHSU) ? {32'h0, b} : {{32{b[31]}}, b};
    p   = ax * bx;
    case (f3)
      F3_MUL:  return p[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: return p[63:32];
      F3_DIV:  return (b == 0) ? 32'hFFFF_FFFF :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb_);
      F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:  return (b == 0) ? a :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb_);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int unsigned latency(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Called at a negedge; drives start for one cycle, then scrambles the operands.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res,
                       input int unsigned lat, input bit track);
    exp_t e;
    int unsigned n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("idle_wait", {31'b0, bus.busy}, 32'h0);
    bus.start   = 1'b1;
    bus.funct3  = f3;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_in   = rd;
    if (track) begin
      e.res = exp_res;
      e.rd  = rd;
      e.cyc = cyc + lat;
      sb.push_back(e);
      accepted++;
    end
    @(negedge clk);
    bus.start   = 1'b0;
    bus.funct3  = 3'($urandom);
    bus.rs1_val = $urandom;
    bus.rs2_val = $urandom;
    bus.rd_in   = 5'($urandom);
  endtask

  task automatic op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] rd);
    issue(f3, a, b, rd, model(f3, a, b), latency(f3, a, b), 1'b1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.done) begin
      dones++;
      if (sb.size() == 0) begin
        chk("spurious_done", {31'b0, bus.done}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("rd_out", {27'b0, bus.rd_out}, {27'b0, e.rd});
        chk("done_cycle", cyc, e.cyc);
      end
    end else if (prev_done) begin
      chk("result_idle_zero", bus.result, 32'h0);
      chk("rd_idle_zero", {27'b0, bus.rd_out}, 32'h0);
    end
    prev_done <= bus.done;
  end

  initial begin
    int unsigned t0;
    int unsigned n;
    logic [2:0]  f3;
    logic [31:0] a, b;
    bus.start = 1'b0; bus.funct3 = '0; bus.rs1_val = '0; bus.rs2_val = '0; bus.rd_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_done", {31'b0, bus.done}, 32'h0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_rd", {27'b0, bus.rd_out}, 32'h0);
    RESET = 1'b0;
    @(negedge clk);

    issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, 34, 1'b1);
    chk("busy_calc", {31'b0, bus.busy}, 32'h1);
    issue(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 34, 1'b1);
    issue(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 34, 1'b1);
    issue(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 34, 1'b1);
    issue(F3_DIV,  32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 34, 1'b1);
    issue(F3_REM,  32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 34, 1'b1);
    issue(F3_DIVU, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'h7FFF_FFFC, 34, 1'b1);
    issue(F3_REMU, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'h0000_0001, 34, 1'b1);
    issue(F3_DIVU, 32'd8, 32'd0, 5'd8,  32'hFFFF_FFFF, 1, 1'b1);
    issue(F3_REMU, 32'd8, 32'd0, 5'd10, 32'd8, 1, 1'b1);
    issue(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, 1'b1);
    issue(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0, 1, 1'b1);

    // Abort: start at T, RESET during T+10, idle at T+11, restart at T+12.
    n = 0;
    while (bus.busy && n < 200) begin @(negedge clk); n++; end
    t0 = cyc;
    issue(F3_MUL, 32'd123, 32'd456, 5'd13, 32'h0, 34, 1'b0);
    repeat (9) @(negedge clk);
    RESET = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'b0, bus.busy}, 32'h0);
    chk("abort_cycle", cyc, t0 + 11);
    RESET = 1'b0;
    @(negedge clk);
    issue(F3_MUL, 32'd123, 32'd456, 5'd14, 32'd56088, 34, 1'b1);

    // Start held high through CALC, FIX and DONE must not be taken.
    issue(F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15,
          model(F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0), 34, 1'b1);
    bus.start = 1'b1;
    for (int unsigned i = 0; i < 100 && bus.busy; i++) @(negedge clk);
    bus.start = 1'b0;
    issue(F3_DIV, 32'd0, 32'd0, 5'd16, 32'hFFFF_FFFF, 1, 1'b1);
    bus.start = 1'b1;
    for (int unsigned i = 0; i < 10 && bus.busy; i++) @(negedge clk);
    bus.start = 1'b0;

    for (int unsigned i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
      b  = (i % 5 == 0) ? 32'h0 : (i % 3 == 0) ? 32'hFFFF_FFFF : $urandom;
      op(f3, a, b, 5'(i + 17));
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'h0);
    chk("done_count", dones, accepted);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
